seg_scan_ctrl: RTL

//  Time-multiplexing scan controller for the 4-digit seven-segment display.

---
 rtl/seg_scan_if.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// -----------------------------------------------------------------------------
// seg_scan_if
//  Bundles the digit-code writer side and the display pin side of the
//  seven-segment scan controller.
//  master : digit-code writer (drives codes, masks, brightness; sees pins)
//  slave  : scan controller   (consumes codes, drives pins)
//  Signals
//   dig0..dig3  5   digit codes, [4]=1 blank, else [3:0] hex value
//   dp_mask     4   decimal point enable per digit (1 = lit)
//   blink_mask  4   blink enable per digit
//   bright      3   brightness level 0..7
//   an          4   anodes, active-low
//   seg         7   segments {g,f,e,d,c,b,a}, active-low
//   dp          1   decimal point, active-low
//   frame_tick  1   one-cycle pulse at the start of each 4-slot frame
// -----------------------------------------------------------------------------
interface seg_scan_if;
   logic [4:0] dig0;
   logic [4:0] dig1;
   logic [4:0] dig2;
   logic [4:0] dig3;
   logic [3:0] dp_mask;
   logic [3:0] blink_mask;
   logic [2:0] bright;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   modport master (
      output dig0, dig1, dig2, dig3, dp_mask, blink_mask, bright,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  dig0, dig1, dig2, dig3, dp_mask, blink_mask, bright,
      output an, seg, dp, frame_tick
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//  Time-multiplexed scan controller for a 4-digit seven-segment display.
//  One anode is strobed per slot of SLOT_CYC cycles. Each slot opens with an
//  all-anodes-off guard to suppress ghosting, then lights the digit for a
//  brightness-dependent window, then stays dark until the slot ends.
//  Digits can be blanked, blinked, and carry a decimal point.
//  Ports
//   clk   in   clock
//   rst   in   synchronous, active-high reset
//   bus   slave side of seg_scan_if (digit codes/masks in, pins out)
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int SLOT_CYC     = 100000,  // cycles per digit slot, >=8, multiple of 8
   parameter int GUARD_CYC    = 64,      // leading dark cycles per slot, < SLOT_CYC/8
   parameter int BLINK_FRAMES = 125      // frames per blink half-period, >=1
) (
   input  logic        clk,
   input  logic        rst,
   seg_scan_if.slave   bus
);

   localparam int CW      = $clog2(SLOT_CYC);
   // Wide enough that 8*SLOT_CYC never overflows in the on-window product.
   localparam int OLW     = CW + 4;
   localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int NUM_DIG = 4;

   typedef enum logic [1:0] {
      S_LATCH,
      S_GUARD,
      S_ON,
      S_OFF
   } state_t;

   state_t                   st, st_nxt;
   logic [CW-1:0]            cnt, cnt_nxt;
   logic [1:0]               idx;
   logic [NUM_DIG-1:0][4:0]  digs;

   // Per-slot snapshot so writer updates never tear a slot in progress.
   logic [4:0]               code_s;
   logic                     dp_s;
   logic                     blink_s;
   logic [2:0]               bright_s;

   logic                     blink_ph;
   logic [FW-1:0]            frame_cnt;

   logic                     slot_end;
   logic                     frame_end;
   logic [2:0]               bright_nxt;
   logic [OLW-1:0]           on_len_nxt;
   logic                     lit;
   logic [3:0]               an_d;
   logic [6:0]               seg_d;
   logic                     dp_d;

   logic [3:0]               an_q;
   logic [6:0]               seg_q;
   logic                     dp_q;
   logic                     tick_q;

   assign digs = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};

   // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Next-state and pin decode.
   always_comb begin
      slot_end   = (cnt == CW'(SLOT_CYC - 1));
      frame_end  = slot_end && (idx == 2'd3);
      cnt_nxt    = slot_end ? '0 : cnt + 1'b1;

      // The state for cnt==1 must already see the brightness being latched now.
      bright_nxt = (st == S_LATCH) ? bus.bright : bright_s;
      on_len_nxt = ((OLW'(bright_nxt) + OLW'(1)) * OLW'(SLOT_CYC)) >> 3;

      st_nxt = S_OFF;
      if (cnt_nxt == '0)
         st_nxt = S_LATCH;
      else if (OLW'(cnt_nxt) < OLW'(GUARD_CYC))
         st_nxt = S_GUARD;
      else if (OLW'(cnt_nxt) < on_len_nxt)
         st_nxt = S_ON;

      lit   = (st == S_ON) && !code_s[4] && !(blink_s && blink_ph);
      an_d  = 4'hF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (lit) begin
         an_d  = ~(4'b0001 << idx);
         seg_d = hex7(code_s[3:0]);
         dp_d  = ~dp_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         idx       <= '0;
         st        <= S_LATCH;
         code_s    <= 5'h10;
         dp_s      <= 1'b0;
         blink_s   <= 1'b0;
         bright_s  <= '0;
         blink_ph  <= 1'b0;
         frame_cnt <= '0;
         an_q      <= 4'hF;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         st  <= st_nxt;
         if (slot_end)
            idx <= idx + 1'b1;

         if (st == S_LATCH) begin
            code_s   <= digs[idx];
            dp_s     <= bus.dp_mask[idx];
            blink_s  <= bus.blink_mask[idx];
            bright_s <= bus.bright;
         end

         // Frame count advances as each frame closes, so the frame that
         // follows reset is frame 0 of the first lit blink half-period.
         if (frame_end) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt <= '0;
               blink_ph  <= ~blink_ph;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end

         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
         tick_q <= (cnt == '0) && (idx == 2'd0);
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_tick = tick_q;

endmodule
